// File: rtl/min3_stream.sv
// Dark-channel stream: per-pixel min(r,g,b), then a trailing 3-tap min
// along the line when MIN3_HWIN_EN is defined (per-pixel min otherwise).
module min3_stream #(
    parameter int LINE_WIDTH = 640
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       Enable,
    input  logic       in_valid,
    input  logic       in_sol,
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    output logic       out_valid,
    output logic [7:0] dataout,
    output logic       out_sol,
    output logic       line_err
);

    localparam logic [11:0] LAST = 12'(LINE_WIDTH - 1);

    logic [7:0]  w_min_rg;
    logic [7:0]  w_min;
    logic        w_new;
    logic        w_err;
    logic [11:0] w_cur;
    logic [11:0] w_col_nxt;
    logic [7:0]  w_win;

    logic [11:0] r_col;
    logic        r_first;
    logic        r_v1;
    logic        r_sol1;
    logic [7:0]  r_p1;

    // r_col==0 after the first pixel means the previous line just wrapped
    always_comb begin
        w_min_rg  = (r < g) ? r : g;
        w_min     = (w_min_rg < b) ? w_min_rg : b;
        w_new     = r_first | in_sol | (r_col == 12'd0);
        w_err     = ~r_first & (in_sol ? (r_col != 12'd0)
                                       : (r_col == 12'd0));
        w_cur     = w_new ? 12'd0 : r_col;
        w_col_nxt = (w_cur == LAST) ? 12'd0 : w_cur + 12'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_first  <= 1'b1;
            r_col    <= 12'd0;
            line_err <= 1'b0;
            r_v1     <= 1'b0;
            r_p1     <= 8'd0;
            r_sol1   <= 1'b0;
        end else if (Enable) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_p1    <= w_min;
                r_sol1  <= in_sol;
                r_first <= 1'b0;
                r_col   <= w_col_nxt;
                if (w_err) begin
                    line_err <= 1'b1;
                end
            end
        end
    end

`ifdef MIN3_HWIN_EN
    logic       r_new1;
    logic [7:0] r_h1;
    logic [7:0] r_h2;
    logic [7:0] w_m12;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_new1 <= 1'b0;
        end else if (Enable && in_valid) begin
            r_new1 <= w_new;
        end
    end

    // 0xFF marks an empty history slot (identity for min)
    always_comb begin
        w_m12 = (r_h1 < r_h2) ? r_h1 : r_h2;
        w_win = r_new1 ? r_p1 : ((r_p1 < w_m12) ? r_p1 : w_m12);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_h1 <= 8'hFF;
            r_h2 <= 8'hFF;
        end else if (Enable && r_v1) begin
            r_h1 <= r_p1;
            r_h2 <= r_new1 ? 8'hFF : r_h1;
        end
    end
`else
    always_comb begin
        w_win = r_p1;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_sol   <= 1'b0;
            dataout   <= 8'd0;
        end else if (Enable) begin
            out_valid <= r_v1;
            out_sol   <= r_v1 & r_sol1;
            if (r_v1) begin
                dataout <= w_win;
            end
        end
    end

endmodule
